lock_key_loader: RTL and testbench

LOCK_KEY_LOADER -- requirements
Module: lock_key_loader

---
 rtl/lock_key_loader.sv | 122 ++++++++++++
 tb/tb_lock_key_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// Serial key loader for a logic-locked core: shifts a key into a shadow register,
// commits it to the active register, and applies it to input/output masks and mux tables.
module lock_key_loader #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 3,
  parameter int N_MUX = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_start,
  input  logic               key_bit,
  input  logic               key_valid,
  output logic               key_ready,
  output logic               key_loaded,
  output logic               key_err,
  input  logic [N_IN-1:0]    pi_new,
  output logic [N_IN-1:0]    pi_out,
  input  logic [N_OUT-1:0]   po_core,
  output logic [N_OUT-1:0]   po_new,
  input  logic [2*N_MUX-1:0] mux_sel,
  output logic [N_MUX-1:0]   mux_out
);

  localparam int KLEN = N_IN + N_OUT + 4*N_MUX;
  localparam int CW   = $clog2(KLEN + 1);

  // state | meaning
  // IDLE  | no key loaded since reset; masks use the active key (zero after reset)
  // LOAD  | accepting serial key bits into the shadow register
  // ARMED | key committed; po_new driven from the active key
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t          state, state_nxt;
  logic [KLEN-1:0] shadow, shadow_nxt, active;
  logic [CW-1:0]   cnt;
  logic [N_OUT-1:0] ko;
  logic            do_restart, do_accept, do_commit, set_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    key_ready  = 1'b0;
    key_loaded = 1'b0;
    do_restart = 1'b0;
    do_accept  = 1'b0;
    do_commit  = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE, ARMED: begin
        key_loaded = (state == ARMED);
        if (key_start) begin
          do_restart = 1'b1;
          state_nxt  = LOAD;
        end else if (key_valid) begin
          set_err = 1'b1;
        end
      end
      LOAD: begin
        key_ready = 1'b1;
        // a start in the same cycle as a valid bit wins; the bit is dropped
        if (key_start) begin
          do_restart = 1'b1;
        end else if (key_valid) begin
          do_accept = 1'b1;
          if (cnt == CW'(KLEN - 1)) begin
            do_commit = 1'b1;
            state_nxt = ARMED;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < KLEN; i++) begin
      if (cnt == CW'(i)) shadow_nxt[i] = key_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      cnt     <= '0;
      key_err <= 1'b0;
    end else begin
      if (do_restart) begin
        shadow  <= '0;
        cnt     <= '0;
        key_err <= 1'b0;
      end else if (do_accept) begin
        shadow <= shadow_nxt;
        cnt    <= cnt + CW'(1);
      end
      // commit includes the bit accepted this cycle
      if (do_commit) active <= shadow_nxt;
      if (set_err)   key_err <= 1'b1;
    end
  end

  assign ko     = active[N_IN +: N_OUT];
  assign pi_out = pi_new ^ active[N_IN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          po_new <= '0;
    else if (key_loaded) po_new <= po_core ^ ko;
    else                 po_new <= '0;
  end

  for (genvar i = 0; i < N_MUX; i++) begin : g_mux
    logic [3:0] kp;
    assign kp         = active[N_IN + N_OUT + 4*i +: 4];
    assign mux_out[i] = kp[mux_sel[2*i +: 2]];
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed plus randomized bench for lock_key_loader against a bit-queue reference model.
module tb_lock_key_loader;
  localparam int N_IN  = 8;
  localparam int N_OUT = 3;
  localparam int N_MUX = 1;
  localparam int KLEN  = N_IN + N_OUT + 4*N_MUX;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_start = 1'b0, key_bit = 1'b0, key_valid = 1'b0;
  logic key_ready, key_loaded, key_err;
  logic [N_IN-1:0]    pi_new = '0;
  logic [N_IN-1:0]    pi_out;
  logic [N_OUT-1:0]   po_core = '0;
  logic [N_OUT-1:0]   po_new;
  logic [2*N_MUX-1:0] mux_sel = '0;
  logic [N_MUX-1:0]   mux_out;

  lock_key_loader #(.N_IN(N_IN), .N_OUT(N_OUT), .N_MUX(N_MUX)) dut (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_bit(key_bit),
    .key_valid(key_valid), .key_ready(key_ready), .key_loaded(key_loaded),
    .key_err(key_err), .pi_new(pi_new), .pi_out(pi_out), .po_core(po_core),
    .po_new(po_new), .mux_sel(mux_sel), .mux_out(mux_out)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // reference model: loading/armed flags, queue of accepted bits, committed key
  bit              m_loading = 1'b0, m_armed = 1'b0, m_err = 1'b0;
  logic [KLEN-1:0] m_key = '0;
  logic [N_OUT-1:0] m_po = '0;
  bit              q[$];
  bit              po_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KLEN-1:0] q_to_key();
    logic [KLEN-1:0] r = '0;
    for (int i = 0; i < q.size(); i++) r[i] = q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_loading = 1'b0; m_armed = 1'b0; m_err = 1'b0;
    m_key = '0; m_po = '0; q.delete();
  endtask

  task automatic model_edge();
    logic [N_OUT-1:0] po_n;
    po_n = m_armed ? (po_core ^ m_key[N_IN +: N_OUT]) : '0;
    if (key_start) begin
      m_loading = 1'b1; m_armed = 1'b0; m_err = 1'b0; q.delete();
    end else if (key_valid && m_loading) begin
      q.push_back(key_bit);
      if (q.size() == KLEN) begin
        m_key = q_to_key();
        m_loading = 1'b0;
        m_armed = 1'b1;
      end
    end else if (key_valid) begin
      m_err = 1'b1;
    end
    m_po = po_n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":key_ready"},  32'(key_ready),  32'(m_loading));
    chk({tag, ":key_loaded"}, 32'(key_loaded), 32'(m_armed));
    chk({tag, ":key_err"},    32'(key_err),    32'(m_err));
    chk({tag, ":pi_out"},     32'(pi_out),     32'(pi_new ^ m_key[N_IN-1:0]));
    chk({tag, ":mux_out"},    32'(mux_out),    32'(m_key[N_IN + N_OUT + int'(mux_sel)]));
    chk({tag, ":po_new"},     32'(po_new),     32'(m_po));
  endtask

  task automatic cycle(input bit s, input bit v, input bit b);
    key_start = s; key_valid = v; key_bit = b;
    pi_new  = N_IN'($urandom);
    mux_sel = (2*N_MUX)'($urandom);
    if (!po_hold) po_core = N_OUT'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic load_key(input logic [KLEN-1:0] k, input bit gapped);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < KLEN; i++) begin
      if (gapped) cycle(1'b0, 1'b0, 1'($urandom));
      cycle(1'b0, 1'b1, k[i]);
    end
    key_valid = 1'b0; key_start = 1'b0;
  endtask

  logic [KLEN-1:0] k_rand, k_old, k_new;

  initial begin
    // reset state
    pi_new = 8'hA5; mux_sel = 2'b11;
    #12;
    chk("rst_pi_out", 32'(pi_out), 32'h0A5);
    chk("rst_mux_out", 32'(mux_out), 32'h0);
    chk("rst_po_new", 32'(po_new), 32'h0);
    chk("rst_loaded", 32'(key_loaded), 32'h0);
    chk("rst_ready", 32'(key_ready), 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // stray valid in IDLE flags an error, start clears it
    cycle(1'b0, 1'b1, 1'b1);
    chk("idle_err", 32'(key_err), 32'h1);

    // gap-free load of 15'h5A3C
    load_key(15'h5A3C, 1'b0);
    chk("k1_loaded", 32'(key_loaded), 32'h1);
    chk("k1_ready", 32'(key_ready), 32'h0);
    chk("k1_pi_out", 32'(pi_out), 32'(pi_new ^ 8'h3C));
    po_hold = 1'b1; po_core = 3'b111;
    cycle(1'b0, 1'b0, 1'b0);
    chk("k1_po_new", 32'(po_new), 32'h5);
    po_hold = 1'b0;

    // same random key gap-free then gapped
    k_rand = KLEN'($urandom);
    load_key(k_rand, 1'b0);
    chk("kr_pi_out", 32'(pi_out), 32'(pi_new ^ k_rand[N_IN-1:0]));
    load_key(~k_rand, 1'b0);
    load_key(k_rand, 1'b1);
    chk("kr_gap_loaded", 32'(key_loaded), 32'h1);
    chk("kr_gap_pi_out", 32'(pi_out), 32'(pi_new ^ k_rand[N_IN-1:0]));
    cycle(1'b0, 1'b0, 1'b0);

    // restart after 7 bits keeps the old key in use
    k_old = k_rand;
    k_new = KLEN'($urandom);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, k_new[i]);
    cycle(1'b1, 1'b0, 1'b0);
    chk("rs_loaded", 32'(key_loaded), 32'h0);
    chk("rs_po_new", 32'(po_new), 32'h0);
    chk("rs_pi_old", 32'(pi_out), 32'(pi_new ^ k_old[N_IN-1:0]));
    for (int i = 0; i < KLEN; i++) cycle(1'b0, 1'b1, k_new[i]);
    chk("rs_new_pi", 32'(pi_out), 32'(pi_new ^ k_new[N_IN-1:0]));

    // valid while armed: error, key unchanged, cleared by start (with simultaneous bit dropped)
    cycle(1'b0, 1'b1, 1'b1);
    chk("arm_err", 32'(key_err), 32'h1);
    chk("arm_key", 32'(pi_out), 32'(pi_new ^ k_new[N_IN-1:0]));
    cycle(1'b1, 1'b1, 1'b1);
    chk("arm_err_clr", 32'(key_err), 32'h0);
    for (int i = 0; i < KLEN; i++) cycle(1'b0, 1'b1, k_old[i]);
    chk("sim_pi", 32'(pi_out), 32'(pi_new ^ k_old[N_IN-1:0]));

    // reset at bit 10 of a load
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, k_new[i]);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mr_ready", 32'(key_ready), 32'h0);
    chk("mr_loaded", 32'(key_loaded), 32'h0);
    chk("mr_err", 32'(key_err), 32'h0);
    chk("mr_po_new", 32'(po_new), 32'h0);
    chk("mr_pi_out", 32'(pi_out), 32'(pi_new));
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    chk("mr_after_pi", 32'(pi_out), 32'(pi_new));

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
